// File: rtl/entropy_reader.sv
// Drains 256-bit health-checked noise words from the OHT output FIFO and streams them
// MSB chunk first over valid/ready; a permanent health failure discards the word in flight.
module entropy_reader #(
    parameter int OUT_WIDTH  = 64,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [255:0]         noise_in,
    input  logic                 fifo_empty,
    input  logic                 good_entropy,
    input  logic                 inter_fail,
    input  logic                 perm_fail,
    output logic                 deque,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 abort,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_done
);
    localparam int CHUNKS = 256 / OUT_WIDTH;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);
    localparam logic [1:0]       LAT_LOAD = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_WAIT, S_STREAM} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_lat_cnt;
    logic [255:0]         r_shift;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_WIDTH-1:0] r_words;
    logic                 w_start;
    logic                 w_abort;
    logic                 w_fire;
    logic                 w_last_fire;

    always_comb begin
        w_start     = !fifo_empty && good_entropy && !inter_fail && !perm_fail;
        // Reset takes priority so a word dropped by reset never raises abort.
        w_abort     = (r_state != S_IDLE) && perm_fail && !rst;
        w_fire      = (r_state == S_STREAM) && out_ready;
        w_last_fire = w_fire && (r_idx == LAST_IDX);

        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_POP;
            S_POP:    w_next = S_WAIT;
            S_WAIT:   if (r_lat_cnt == 2'd0) w_next = S_STREAM;
            S_STREAM: if (w_last_fire) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= 2'd0;
            r_shift   <= '0;
            r_idx     <= '0;
            r_words   <= '0;
        end else begin
            r_state <= w_next;
            if (w_abort) begin
                r_shift <= '0;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    S_POP: begin
                        r_lat_cnt <= LAT_LOAD;
                        r_idx     <= '0;
                    end
                    S_WAIT: begin
                        if (r_lat_cnt == 2'd0) r_shift <= noise_in;
                        else                   r_lat_cnt <= r_lat_cnt - 2'd1;
                    end
                    S_STREAM: begin
                        if (w_last_fire) begin
                            r_shift <= '0;
                            r_idx   <= '0;
                            if (r_words != '1) r_words <= r_words + 1'b1;
                        end else if (w_fire) begin
                            r_shift <= r_shift << OUT_WIDTH;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        deque      = (r_state == S_POP) && !perm_fail && !rst;
        out_valid  = (r_state == S_STREAM);
        out_data   = out_valid ? r_shift[255 -: OUT_WIDTH] : '0;
        out_last   = out_valid && (r_idx == LAST_IDX);
        abort      = w_abort;
        busy       = (r_state != S_IDLE);
        words_done = r_words;
    end

endmodule

// File: tb/tb_entropy_reader.sv
// Directed bench for entropy_reader: three instances cover 64/1, 32/3 and 256/2
// chunk-width/read-latency configurations, each fed by a small FIFO model.
module tb_entropy_reader;
    logic clk = 1'b0;
    logic rst, good, inter, perm, ready;
    always #5 clk = ~clk;

    logic [255:0] W [8];
    int pass_cnt = 0;
    int total_cnt = 0;

    // Instance A: OUT_WIDTH=64, RD_LATENCY=1, CNT_WIDTH=2
    logic [255:0] a_noise;
    logic         a_empty, a_deque, a_valid, a_last, a_abort, a_busy;
    logic [63:0]  a_data;
    logic [1:0]   a_words;
    int           a_rd = 0, a_wr = 0;
    assign a_empty = (a_rd >= a_wr);
    always @(posedge clk) if (a_deque) begin a_noise <= W[a_rd[2:0]]; a_rd <= a_rd + 1; end

    entropy_reader #(.OUT_WIDTH(64), .RD_LATENCY(1), .CNT_WIDTH(2)) u_a (
        .clk(clk), .rst(rst), .noise_in(a_noise), .fifo_empty(a_empty),
        .good_entropy(good), .inter_fail(inter), .perm_fail(perm), .deque(a_deque),
        .out_data(a_data), .out_valid(a_valid), .out_ready(ready), .out_last(a_last),
        .abort(a_abort), .busy(a_busy), .words_done(a_words));

    // Instance B: OUT_WIDTH=32, RD_LATENCY=3, CNT_WIDTH=16
    logic [255:0] b_noise;
    logic         b_empty, b_deque, b_valid, b_last, b_abort, b_busy;
    logic [31:0]  b_data;
    logic [15:0]  b_words;
    int           b_rd = 0, b_wr = 0;
    assign b_empty = (b_rd >= b_wr);
    always @(posedge clk) if (b_deque) begin b_noise <= W[b_rd[2:0]]; b_rd <= b_rd + 1; end

    entropy_reader #(.OUT_WIDTH(32), .RD_LATENCY(3), .CNT_WIDTH(16)) u_b (
        .clk(clk), .rst(rst), .noise_in(b_noise), .fifo_empty(b_empty),
        .good_entropy(good), .inter_fail(inter), .perm_fail(perm), .deque(b_deque),
        .out_data(b_data), .out_valid(b_valid), .out_ready(ready), .out_last(b_last),
        .abort(b_abort), .busy(b_busy), .words_done(b_words));

    // Instance C: OUT_WIDTH=256, RD_LATENCY=2, CNT_WIDTH=16
    logic [255:0] c_noise;
    logic         c_empty, c_deque, c_valid, c_last, c_abort, c_busy;
    logic [255:0] c_data;
    logic [15:0]  c_words;
    int           c_rd = 0, c_wr = 0;
    assign c_empty = (c_rd >= c_wr);
    always @(posedge clk) if (c_deque) begin c_noise <= W[c_rd[2:0]]; c_rd <= c_rd + 1; end

    entropy_reader #(.OUT_WIDTH(256), .RD_LATENCY(2), .CNT_WIDTH(16)) u_c (
        .clk(clk), .rst(rst), .noise_in(c_noise), .fifo_empty(c_empty),
        .good_entropy(good), .inter_fail(inter), .perm_fail(perm), .deque(c_deque),
        .out_data(c_data), .out_valid(c_valid), .out_ready(ready), .out_last(c_last),
        .abort(c_abort), .busy(c_busy), .words_done(c_words));

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Expected chunk j (MSB first) of word k for chunk width w.
    function automatic logic [255:0] chunk(input int k, input int w, input int j);
        logic [255:0] v;
        v = W[k] << (w * j);
        return v >> (256 - w);
    endfunction

    task automatic wait_valid(input int inst, input string tag);
        logic f;
        f = 1'b0;
        for (int n = 0; n < 12; n++) begin
            step(); mid();
            if ((inst == 0 && a_valid) || (inst == 1 && b_valid) || (inst == 2 && c_valid)) begin
                f = 1'b1;
                break;
            end
        end
        check(tag, 256'(f), 256'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic f;
        logic seen;
        int   n, k;
        int   pat [7];
        pat = '{1, 0, 0, 1, 0, 1, 1};

        W[0] = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
        for (int i = 1; i < 8; i++)
            W[i] = {W[i-1][223:0], W[i-1][255:224]} ^ {8{32'(32'h9E3779B9 + i)}};

        rst = 1'b1; good = 1'b0; inter = 1'b0; perm = 1'b0; ready = 1'b0;
        step(); step(); mid();
        check("rst_deque", 256'(a_deque), 256'd0);
        check("rst_valid", 256'(a_valid), 256'd0);
        check("rst_data", 256'(a_data), 256'd0);
        check("rst_last", 256'(a_last), 256'd0);
        check("rst_abort", 256'(a_abort), 256'd0);
        check("rst_busy", 256'(a_busy), 256'd0);
        check("rst_words", 256'(a_words), 256'd0);
        step(); rst = 1'b0;

        // C: single 256-bit chunk, out_last high for the whole stream phase
        step(); c_wr = 1; good = 1'b1; ready = 1'b0;
        wait_valid(2, "c_wait_valid");
        check("c_last_held", 256'(c_last), 256'd1);
        check("c_data", c_data, W[0]);
        step(); mid();
        check("c_valid_held", 256'(c_valid), 256'd1);
        check("c_data_held", c_data, W[0]);
        step(); ready = 1'b1; mid();
        check("c_last_fire", 256'(c_last), 256'd1);
        step(); ready = 1'b0; mid();
        check("c_valid_after", 256'(c_valid), 256'd0);
        check("c_words", 256'(c_words), 256'd1);

        // B: three words back to back, RD_LATENCY=3, 8 chunks each
        step(); b_wr = 3; ready = 1'b1;
        f = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(); mid();
            if (b_deque) begin f = 1'b1; break; end
        end
        check("b_first_deque", 256'(f), 256'd1);
        for (int w = 0; w < 3; w++) begin
            if (w > 0) begin
                n = 0;
                for (int i = 0; i < 8; i++) begin
                    step(); mid(); n++;
                    if (b_deque) break;
                end
                check("b_deque_gap", 256'(n), 256'd2);
            end
            n = 0;
            for (int i = 0; i < 8; i++) begin
                step(); mid(); n++;
                if (b_valid) break;
            end
            check("b_deque_to_valid", 256'(n), 256'd4);
            for (int j = 0; j < 8; j++) begin
                if (j > 0) begin step(); mid(); end
                check("b_data", 256'(b_data), chunk(w, 32, j));
                check("b_last", 256'(b_last), 256'(j == 7));
            end
        end
        step(); mid();
        check("b_valid_after", 256'(b_valid), 256'd0);
        check("b_busy_after", 256'(b_busy), 256'd0);
        check("b_words", 256'(b_words), 256'd3);

        // A basic drain
        step(); a_wr = 1; mid();
        check("a_idle_no_deque", 256'(a_deque), 256'd0);
        step(); mid();
        check("a_deque", 256'(a_deque), 256'd1);
        check("a_busy_pop", 256'(a_busy), 256'd1);
        step(); mid();
        check("a_deque_single", 256'(a_deque), 256'd0);
        check("a_wait_valid", 256'(a_valid), 256'd0);
        for (int j = 0; j < 4; j++) begin
            step(); mid();
            check("a_basic_valid", 256'(a_valid), 256'd1);
            check("a_basic_data", 256'(a_data), chunk(0, 64, j));
            check("a_basic_last", 256'(a_last), 256'(j == 3));
        end
        step(); mid();
        check("a_basic_valid_after", 256'(a_valid), 256'd0);
        check("a_basic_data_after", 256'(a_data), 256'd0);
        check("a_basic_busy", 256'(a_busy), 256'd0);
        check("a_basic_words", 256'(a_words), 256'd1);

        // A backpressure
        step(); a_wr = 2; ready = 1'b1;
        wait_valid(0, "a_bp_wait");
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin step(); ready = pat[i][0]; mid(); end
            check("a_bp_valid", 256'(a_valid), 256'd1);
            check("a_bp_data", 256'(a_data), chunk(1, 64, k));
            check("a_bp_last", 256'(a_last), 256'(k == 3));
            if (pat[i] != 0) k++;
        end
        step(); ready = 1'b1; mid();
        check("a_bp_valid_after", 256'(a_valid), 256'd0);
        check("a_bp_words", 256'(a_words), 256'd2);

        // A gating: good_entropy low, then inter_fail high
        step(); a_wr = 3; good = 1'b0; mid();
        seen = a_deque | a_busy;
        for (int i = 0; i < 19; i++) begin step(); mid(); seen |= a_deque | a_busy; end
        step(); good = 1'b1; inter = 1'b1; mid();
        seen |= a_deque | a_busy;
        for (int i = 0; i < 9; i++) begin step(); mid(); seen |= a_deque | a_busy; end
        check("a_gate_blocked", 256'(seen), 256'd0);
        step(); inter = 1'b0; mid();
        check("a_gate_release_idle", 256'(a_deque), 256'd0);
        step(); mid();
        check("a_gate_deque", 256'(a_deque), 256'd1);

        // A abort during the second chunk handshake
        step(); mid();
        step(); mid();
        check("a_ab_chunk0", 256'(a_data), chunk(2, 64, 0));
        step(); perm = 1'b1; mid();
        check("a_ab_abort", 256'(a_abort), 256'd1);
        check("a_ab_chunk1", 256'(a_data), chunk(2, 64, 1));
        step(); perm = 1'b0; mid();
        check("a_ab_abort_pulse", 256'(a_abort), 256'd0);
        check("a_ab_valid", 256'(a_valid), 256'd0);
        check("a_ab_busy", 256'(a_busy), 256'd0);
        check("a_ab_words", 256'(a_words), 256'd2);

        // A next word streams from chunk 0
        step(); a_wr = 4;
        wait_valid(0, "a_next_wait");
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin step(); mid(); end
            check("a_next_data", 256'(a_data), chunk(3, 64, j));
        end
        step(); mid();
        check("a_next_words", 256'(a_words), 256'd3);

        // A saturation of the 2-bit counter
        step(); a_wr = 5;
        wait_valid(0, "a_sat_wait");
        for (int j = 0; j < 3; j++) begin step(); mid(); end
        check("a_sat_last", 256'(a_last), 256'd1);
        step(); mid();
        check("a_sat_words", 256'(a_words), 256'd3);
        check("a_sat_busy", 256'(a_busy), 256'd0);

        // A reset mid-stream after chunk 0 was accepted
        step(); a_wr = 6;
        wait_valid(0, "a_rst_wait");
        step(); rst = 1'b1; mid();
        check("a_rst_no_abort", 256'(a_abort), 256'd0);
        check("a_rst_chunk1", 256'(a_data), chunk(5, 64, 1));
        step(); rst = 1'b0; mid();
        check("a_rst_valid", 256'(a_valid), 256'd0);
        check("a_rst_data", 256'(a_data), 256'd0);
        check("a_rst_last", 256'(a_last), 256'd0);
        check("a_rst_abort", 256'(a_abort), 256'd0);
        check("a_rst_busy", 256'(a_busy), 256'd0);
        check("a_rst_deque", 256'(a_deque), 256'd0);
        check("a_rst_words", 256'(a_words), 256'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/entropy_reader.md
Name: entropy_reader

Overview:
Drains 256-bit health-checked noise words from the OHT output FIFO. Pops one word only when the FIFO is non-empty, the entropy monitor reports good, and no health failure is active. Streams each word as OUT_WIDTH-bit chunks over a valid/ready interface to the downstream conditioner/seed loader, MSB chunk first. Aborts a partially sent word on permanent health failure.

Parameters:
OUT_WIDTH, 64, chunk width. Must divide 256 evenly; legal values 8, 16, 32, 64, 128, 256.
RD_LATENCY, 1, cycles from the deque pulse to valid read data at noise_in. Legal range 1-3.
CNT_WIDTH, 16, width of the words_done counter.

Ports:
clk  in  1  clock
rst  in  1  reset
noise_in  in  256  FIFO read data; bit 255 is the oldest sample
fifo_empty  in  1  FIFO empty flag
good_entropy  in  1  entropy monitor reports a 45-55% ones ratio
inter_fail  in  1  intermittent health failure
perm_fail  in  1  permanent health failure
deque  out  1  single-cycle FIFO pop strobe
out_data  out  OUT_WIDTH  chunk data
out_valid  out  1  chunk valid
out_ready  in  1  downstream accept
out_last  out  1  final chunk of the current word
abort  out  1  one-cycle pulse; the current word was discarded
busy  out  1  state is not IDLE
words_done  out  CNT_WIDTH  count of fully delivered words; saturating

Behaviour:
- Reset: rst is synchronous and active-high on clk. On reset:
  - state = IDLE
  - deque, out_valid, out_last, abort, busy = 0
  - out_data = 0, words_done = 0, shift register = 0, latency counter = 0
- Reset mid-operation: the partial word is dropped silently, with no abort pulse.
- States: IDLE, POP, WAIT, STREAM.
- IDLE:
  - Go to POP when fifo_empty=0 && good_entropy=1 && inter_fail=0 && perm_fail=0.
  - Otherwise stay in IDLE.
- POP (lasts exactly 1 cycle):
  - deque = (state==POP) && !perm_fail. This is combinational from state, so deque is exactly one cycle wide per word.
  - Next state is WAIT; the latency counter loads RD_LATENCY-1.
- WAIT:
  - If the counter is 0, capture noise_in into the 256-bit shift register and go to STREAM.
  - Otherwise decrement the counter.
  - With RD_LATENCY=1: deque is high in cycle t, noise_in is sampled at the end of cycle t+1, and out_valid first rises in cycle t+2.
- STREAM:
  - out_valid=1. out_data = shift_reg[255 -: OUT_WIDTH].
  - On out_valid && out_ready: shift left by OUT_WIDTH (zero fill) and increment the chunk index.
  - out_data stays stable while out_ready=0.
  - out_last=1 when chunk index == 256/OUT_WIDTH-1.
  - On the last handshake: words_done += 1 (saturates at all-ones), shift register cleared, go to IDLE.
  - Minimum spacing: last handshake in cycle s gives IDLE in s+1 and the next deque in s+2.
- Abort:
  - perm_fail=1 in POP, WAIT or STREAM forces IDLE next cycle.
  - abort pulses 1 in that same cycle and the shift register is cleared.
  - words_done is unchanged.
  - If perm_fail coincides with an out_ready handshake, abort wins. That chunk is not counted, and the consumer discards all chunks of the word since its last out_last.
  - A word already popped during POP/WAIT is discarded; it is not re-read.
- inter_fail and good_entropy:
  - inter_fail blocks only the IDLE->POP transition. It never aborts an in-flight word.
  - good_entropy deasserting mid-word does not abort.
- Outputs:
  - out_data = 0 whenever out_valid=0.
  - out_last=0 whenever out_valid=0.
  - busy = (state != IDLE).
- Width rules:
  - Chunk index width is clog2(256/OUT_WIDTH), minimum 1.
  - OUT_WIDTH=256 gives a single chunk with out_last=1 throughout STREAM.
- deque is never asserted while fifo_empty=1 was seen in the preceding IDLE cycle. The block does not re-check empty in POP (FIFO guarantees no underflow on a single pop).

Test Plan:
- Basic drain: FIFO holds one word 0x0123...CDEF (256b), good_entropy=1, out_ready=1 always, OUT_WIDTH=64 -> one deque pulse; 4 chunks MSB-first on consecutive cycles starting 2 cycles after deque; out_last on the 4th chunk; words_done=1; busy returns to 0.
- Backpressure: same word, out_ready toggling 1,0,0,1,0,1,1 -> each chunk is held stable while out_ready=0; exactly 4 handshakes; no chunk repeated or skipped.
- Gating: fifo_empty=0 with good_entropy=0 for 20 cycles, then inter_fail=1 with good_entropy=1 for 10 cycles -> deque never asserts; asserting good_entropy with inter_fail=0 gives deque 1 cycle after IDLE sees the condition.
- Abort: perm_fail pulses during the 2nd chunk handshake -> abort=1 for 1 cycle, out_valid=0 next cycle, words_done unchanged; the next word streams normally from chunk 0.
- Back-to-back and latency: 3 words queued, RD_LATENCY=3, OUT_WIDTH=32 -> 8 chunks per word; deque-to-first-valid = 4 cycles; next deque 2 cycles after each last handshake; words_done=3.
- Reset mid-STREAM after chunk 1, plus a saturation run with CNT_WIDTH=2 and 5 words -> all outputs 0 the cycle after reset with no abort pulse; words_done saturates at 3.
